// File: rtl/control_seq_pkg.sv
// Shared encodings for the accumulator CPU sequencer:
// state codes, opcode nibbles and ALU selects.
package control_seq_pkg;

  typedef enum logic [2:0] {
    S_START   = 3'd0,
    S_PREP    = 3'd1,
    S_WAIT    = 3'd2,
    S_LOAD    = 3'd3,
    S_DECODE  = 3'd4,
    S_EXEC_RD = 3'd5,
    S_EXEC_WB = 3'd6,
    S_HALT    = 3'd7
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_JMP   = 4'h4;
  localparam logic [3:0] OP_JN    = 4'h5;
  localparam logic [3:0] OP_JZ    = 4'h6;
  localparam logic [3:0] OP_NOP   = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

endpackage

// File: rtl/mem_wait_ctr.sv
// Memory wait-state counter shared by instruction fetch
// and operand read; done marks the last wait cycle.
module mem_wait_ctr #(
  parameter int MEM_WAIT = 0
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clr,
  input  logic inc,
  output logic done
);

  localparam logic [1:0] LAST =
    (MEM_WAIT > 0) ? 2'(MEM_WAIT - 1) : 2'd0;

  logic [1:0] cnt;

  always_ff @(negedge CLK or posedge RESET) begin
    if (RESET)    cnt <= 2'd0;
    else if (clr) cnt <= 2'd0;
    else if (inc) cnt <= cnt + 2'd1;
  end

  assign done = (cnt == LAST);

endmodule

// File: rtl/control_seq.sv
// Instruction sequencer: multi-byte fetch with wait states,
// decode, and load/store/ALU/branch/halt execution.
module control_seq
  import control_seq_pkg::*;
#(
  parameter int INSTR_BYTES = 2,
  parameter int MEM_WAIT    = 0
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [7:0]             opcode,
  input  logic                   NFLG,
  input  logic                   ZFLG,
  output logic [2:0]             STATE,
  output logic [INSTR_BYTES-1:0] LOAD_IR,
  output logic                   LOAD_AC,
  output logic                   LOAD_PC,
  output logic                   INC_PC,
  output logic                   FETCH,
  output logic                   ADDR_SEL,
  output logic                   STORE_MEM,
  output logic [1:0]             ALU_OP,
  output logic                   HALTED,
  output logic                   ILLEGAL
);

  localparam logic [1:0] IDX_LAST = 2'(INSTR_BYTES - 1);

  state_t     state;
  logic [1:0] byte_idx;
  logic       rd_op;
  logic [3:0] op_q;
  logic       wait_done;
  logic       ctr_clr;
  logic       ctr_inc;
  logic [3:0] opc;
  logic       unused_opcode;

  assign opc           = opcode[7:4];
  assign unused_opcode = ^opcode[3:0];
  assign STATE         = state;

  // Counter starts clean at every memory access.
  assign ctr_clr = (state == S_PREP) || (state == S_EXEC_RD)
                || ((state == S_WAIT) && wait_done);
  assign ctr_inc = (state == S_WAIT) && !wait_done;

  mem_wait_ctr #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .CLK   (CLK),
    .RESET (RESET),
    .clr   (ctr_clr),
    .inc   (ctr_inc),
    .done  (wait_done)
  );

  always_ff @(negedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= S_START;
      byte_idx <= 2'd0;
      rd_op    <= 1'b0;
      op_q     <= OP_NOP;
    end else begin
      unique case (state)
        S_START: state <= S_PREP;
        S_PREP: begin
          rd_op <= 1'b0;
          state <= (MEM_WAIT > 0) ? S_WAIT : S_LOAD;
        end
        S_WAIT: begin
          if (wait_done)
            state <= rd_op ? S_EXEC_WB : S_LOAD;
        end
        S_LOAD: begin
          if (byte_idx == IDX_LAST) begin
            byte_idx <= 2'd0;
            state    <= S_DECODE;
          end else begin
            byte_idx <= byte_idx + 2'd1;
            state    <= S_PREP;
          end
        end
        S_DECODE: begin
          op_q <= opc;
          case (opc)
            OP_LOAD, OP_ADD, OP_SUB: state <= S_EXEC_RD;
            OP_HALT:                 state <= S_HALT;
            default:                 state <= S_PREP;
          endcase
        end
        S_EXEC_RD: begin
          rd_op <= 1'b1;
          state <= (MEM_WAIT > 0) ? S_WAIT : S_EXEC_WB;
        end
        S_EXEC_WB: state <= S_PREP;
        S_HALT:    state <= S_HALT;
        default:   state <= S_START;
      endcase
    end
  end

  always_comb begin
    LOAD_AC   = 1'b0;
    LOAD_PC   = 1'b0;
    INC_PC    = 1'b0;
    FETCH     = 1'b0;
    ADDR_SEL  = 1'b0;
    STORE_MEM = 1'b0;
    ALU_OP    = ALU_PASS;
    HALTED    = 1'b0;
    ILLEGAL   = 1'b0;
    for (int i = 0; i < INSTR_BYTES; i++)
      LOAD_IR[i] = (state == S_LOAD) && (byte_idx == 2'(i));
    unique case (state)
      S_START: LOAD_PC = 1'b1;
      S_PREP:  FETCH   = 1'b1;
      // Operand-read waits keep the operand address on the bus.
      S_WAIT: begin
        FETCH    = 1'b1;
        ADDR_SEL = rd_op;
      end
      S_LOAD:  INC_PC  = 1'b1;
      S_DECODE: begin
        case (opc)
          OP_STORE: STORE_MEM = 1'b1;
          OP_JMP:   LOAD_PC   = 1'b1;
          OP_JN:    LOAD_PC   = NFLG;
          OP_JZ:    LOAD_PC   = ZFLG;
          OP_LOAD, OP_ADD, OP_SUB,
          OP_NOP, OP_HALT: ;
          default:  ILLEGAL   = 1'b1;
        endcase
      end
      S_EXEC_RD: begin
        FETCH    = 1'b1;
        ADDR_SEL = 1'b1;
      end
      S_EXEC_WB: begin
        LOAD_AC = 1'b1;
        if (op_q == OP_ADD)      ALU_OP = ALU_ADD;
        else if (op_q == OP_SUB) ALU_OP = ALU_SUB;
        else                     ALU_OP = ALU_PASS;
      end
      S_HALT:  HALTED = 1'b1;
      default: ;
    endcase
  end

endmodule
